// File: rtl/adder_2_bit.sv
// Registered 2-bit ripple-carry adder with carry-in/carry-out.
// A valid flag travels alongside the sum with a one-cycle latency.
module adder_2_bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] A,
    input  logic [1:0] B,
    input  logic       Cin,
    input  logic       in_valid,
    output logic [1:0] S,
    output logic       Cout,
    output logic       out_valid
);

    // One full-adder cell, returned as {carry, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    logic [1:0] stage0;
    logic [1:0] stage1;

    always_comb begin
        stage0 = full_add(A[0], B[0], Cin);
        stage1 = full_add(A[1], B[1], stage0[1]);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S         <= 2'b00;
            Cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                S    <= {stage1[0], stage0[0]};
                Cout <= stage1[1];
            end
        end
    end

endmodule

// File: tb/tb_adder_2_bit.sv
// Self-checking bench for adder_2_bit: directed, hold, reset, exhaustive
// streaming and random traffic against a plain-arithmetic reference model.
module tb_adder_2_bit;

    logic       clk;
    logic       rst_n;
    logic [1:0] A;
    logic [1:0] B;
    logic       Cin;
    logic       in_valid;
    logic [1:0] S;
    logic       Cout;
    logic       out_valid;

    int checks;
    int failures;

    // {A, B, Cin} stimulus and expected {Cout, S} taken from hand arithmetic.
    localparam logic [4:0] VEC [8] = '{
        5'b00100, 5'b00000, 5'b10000, 5'b10010, 5'b10011,
        5'b01011, 5'b11111, 5'b11001
    };
    localparam logic [2:0] EXP [8] = '{
        3'b010, 3'b000, 3'b010, 3'b011, 3'b100,
        3'b011, 3'b111, 3'b100
    };

    adder_2_bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .in_valid  (in_valid),
        .S         (S),
        .Cout      (Cout),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] got;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A = 2'b00; B = 2'b00; Cin = 1'b0;
        #1;
        checks++;
        if ({Cout, S, out_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_initial: got {Cout,S,out_valid}=%b required 0000", {Cout, S, out_valid});
        end
        for (int i = 0; i < 3; i++) begin
            A = 2'($urandom); B = 2'($urandom); Cin = 1'($urandom);
            in_valid = 1'b1;
            tick();
            got = {Cout, S};
            checks++;
            if (got !== 3'b000 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cycle %0d: got {Cout,S}=%b out_valid=%b required 000/0", i, got, out_valid);
            end
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        checks++;
        if ({Cout, S, out_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_release: got {Cout,S,out_valid}=%b required 0000", {Cout, S, out_valid});
        end
    endtask

    task automatic test_directed();
        for (int i = 0; i < 5; i++) begin
            {A, B, Cin} = VEC[i];
            in_valid = 1'b1;
            tick();
            checks++;
            if ({Cout, S} !== EXP[i] || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL directed %0d: got {Cout,S}=%b out_valid=%b required %b/1", i, {Cout, S}, out_valid, EXP[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_carry();
        for (int i = 5; i < 8; i++) begin
            {A, B, Cin} = VEC[i];
            in_valid = 1'b1;
            tick();
            checks++;
            if ({Cout, S} !== EXP[i] || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL carry %0d: got {Cout,S}=%b out_valid=%b required %b/1", i, {Cout, S}, out_valid, EXP[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_hold();
        A = 2'b10; B = 2'b01; Cin = 1'b0;
        in_valid = 1'b1;
        tick();
        checks++;
        if ({Cout, S} !== 3'b011 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL hold_load: got {Cout,S}=%b out_valid=%b required 011/1", {Cout, S}, out_valid);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 5) begin
                A = 2'b11; B = 2'b11; Cin = 1'b1;
            end else begin
                A = 2'bxx; B = 2'bxx; Cin = 1'bx;
            end
            tick();
            checks++;
            if ({Cout, S} !== 3'b011 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL hold cycle %0d: got {Cout,S}=%b out_valid=%b required 011/0", i, {Cout, S}, out_valid);
            end
        end
        A = 2'b00; B = 2'b00; Cin = 1'b0;
    endtask

    task automatic test_async_reset();
        A = 2'b11; B = 2'b10; Cin = 1'b1;
        in_valid = 1'b1;
        tick();
        checks++;
        if ({Cout, S} !== 3'b110 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL async_pre: got {Cout,S}=%b out_valid=%b required 110/1", {Cout, S}, out_valid);
        end
        A = 2'b01; B = 2'b01; Cin = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({Cout, S, out_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL async_clear: got {Cout,S,out_valid}=%b required 0000", {Cout, S, out_valid});
        end
        tick();
        checks++;
        if ({Cout, S, out_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL async_discard: got {Cout,S,out_valid}=%b required 0000", {Cout, S, out_valid});
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        checks++;
        if ({Cout, S, out_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL async_release: got {Cout,S,out_valid}=%b required 0000", {Cout, S, out_valid});
        end
    endtask

    task automatic test_streaming();
        int expected [$];
        int want;
        for (int i = 0; i < 32; i++) begin
            A   = 2'(i >> 3);
            B   = 2'(i >> 1);
            Cin = 1'(i);
            in_valid = 1'b1;
            expected.push_back(int'(A) + int'(B) + int'(Cin));
            tick();
            want = expected.pop_front();
            checks++;
            if (int'({Cout, S}) != want || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL stream %0d: got sum=%0d out_valid=%b required %0d/1", i, {Cout, S}, out_valid, want);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int model_sum;
        int model_valid;
        model_sum = int'({Cout, S});
        for (int i = 0; i < 60; i++) begin
            A   = 2'($urandom);
            B   = 2'($urandom);
            Cin = 1'($urandom);
            in_valid = 1'($urandom_range(0, 3) != 0);
            if (in_valid) model_sum = int'(A) + int'(B) + int'(Cin);
            model_valid = int'(in_valid);
            tick();
            checks++;
            if (int'({Cout, S}) != model_sum || int'(out_valid) != model_valid) begin
                failures++;
                $display("FAIL random %0d: got sum=%0d out_valid=%b required %0d/%0d", i, {Cout, S}, out_valid, model_sum, model_valid);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_carry();
        test_hold();
        test_async_reset();
        test_streaming();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_2_bit.md
Name: adder_2_bit

Overview:
Registered 2-bit ripple-carry adder with carry-in and carry-out. It sums two 2-bit operands and a carry-in, and registers the result with a one-cycle latency. A valid flag travels with the data. It is a small arithmetic leaf block, used standalone or chained through Cin/Cout to build wider adders.

Parameters:
None. Width is fixed at 2 bits.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  reset; asynchronous, active-low.
A  input  2  operand A, unsigned.
B  input  2  operand B, unsigned.
Cin  input  1  carry-in.
in_valid  input  1  when high, A/B/Cin are sampled this cycle.
S  output  2  registered sum bits, {A+B+Cin}[1:0].
Cout  output  1  registered carry-out, {A+B+Cin}[2].
out_valid  output  1  high for exactly one cycle per accepted input, aligned with the S/Cout update.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: S=2'b00, Cout=0, out_valid=0 immediately, regardless of clk.
- Deassertion of rst_n takes effect on the next rising clk edge.
- Combinational datapath: two cascaded full-adder stages.
  - Stage 0: s0 = A[0]^B[0]^Cin; c1 = majority(A[0], B[0], Cin).
  - Stage 1: s1 = A[1]^B[1]^c1; c2 = majority(A[1], B[1], c1).
  - Result {c2, s1, s0} equals the 3-bit unsigned sum A+B+Cin, range 0..7.
- Register stage, on a rising clk edge with rst_n=1:
  - If in_valid=1: S<={s1,s0}, Cout<=c2, out_valid<=1.
  - If in_valid=0: S and Cout hold their previous values; out_valid<=0.
- Latency: one clock from the sampling edge to visible outputs. Back-to-back inputs are accepted every cycle; throughput is 1 result per clock.
- No backpressure: out_valid is informational only.
- Inputs that are X/Z while in_valid=0 must not corrupt S/Cout.
- Reset asserted mid-operation:
  - Any result launched but not yet observed is discarded.
  - Outputs go to 0 asynchronously.
- Wrap-around: the maximum 3+3+1=7 gives S=2'b11, Cout=1. Carry-out is the only overflow indication.
- No other state. No combinational path from inputs to outputs.

Test Plan:
1. Reset: hold rst_n=0 for 3 clocks with random inputs and in_valid=1 -> S=00, Cout=0, out_valid=0 throughout. Assert rst_n=0 asynchronously mid-cycle after a valid result -> outputs clear before the next edge.
2. Directed sums, one per cycle with in_valid=1:
   - A=00, B=10, Cin=0 -> S=10, Cout=0.
   - A=00, B=00, Cin=0 -> S=00, Cout=0.
   - A=10, B=00, Cin=0 -> S=10, Cout=0.
   - A=10, B=01, Cin=0 -> S=11, Cout=0.
   - A=10, B=01, Cin=1 -> S=00, Cout=1.
   - Each result appears one cycle after sampling, with out_valid=1.
3. Carry chain and maximum: A=01, B=01, Cin=1 -> S=11, Cout=0. A=11, B=11, Cin=1 -> S=11, Cout=1. A=11, B=00, Cin=1 -> S=00, Cout=1.
4. Hold: load A=10, B=01, Cin=0 (S=11), then drive in_valid=0 with A=11, B=11 and with X inputs for 5 cycles -> S stays 11, Cout stays 0, out_valid=0.
5. Exhaustive streaming: all 32 combinations of A, B, Cin back-to-back with in_valid=1 -> every cycle {Cout,S} equals the previous cycle's A+B+Cin, and out_valid stays high.
